// File: rtl/weight_row_feeder_pkg.sv
`timescale 1ns/1ps
// Shared array geometry and feeder FSM encodings for the weight-load path.
// The row width and rows-per-tile of the feeder are derived from the array shape.
package weight_row_feeder_pkg;

  localparam int ARRAY_ROW  = 16;
  localparam int ARRAY_COL  = 4;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_SERVE = 2'd1,
    FEED_DONE  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/row_fifo.sv
`timescale 1ns/1ps
// Synchronous row FIFO with a registered occupancy count; the head entry is visible combinationally.
// i_pop_n may release several entries at once so an aborted tile can be flushed in one cycle.
module row_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic [LW-1:0]    i_pop_n,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;

  // full/empty come only from the registered level, so a pop never frees a slot in the same cycle
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr <= r_rd_ptr + i_pop_n[AW-1:0];
      r_level  <= r_level + LW'(w_push_ok) - i_pop_n;
    end
  end

endmodule

// File: rtl/weight_row_feeder.sv
`timescale 1ns/1ps
// Weight-row producer for the core: buffers DMA rows against requested credit and replays
// exactly one tile of rows while the core holds its load enable.
module weight_row_feeder
  import weight_row_feeder_pkg::*;
#(
  parameter int ROWS_PER_TILE = ARRAY_ROW,
  parameter int ROW_WIDTH     = ARRAY_COL * DATA_WIDTH,
  parameter int FIFO_DEPTH    = 32,
  parameter int CREDIT_WIDTH  = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROW_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 i_dma_req,
  input  logic                 i_load_en,
  output logic [ROW_WIDTH-1:0] o_weight_vec,
  output logic                 o_weight_valid,
  output logic                 o_tile_done,
  output logic                 o_err_abort,
  output logic [LW-1:0]        o_fifo_level,
  output logic [1:0]           o_dbg_state
);

  // Handshakes: an ingress beat transfers on a clock edge where s_axis_tvalid and s_axis_tready
  // are both high; s_axis_tready never depends on s_axis_tvalid. o_weight_valid qualifies
  // o_weight_vec for exactly the cycle it is high and carries no back-pressure.

  localparam int CW = CREDIT_WIDTH;
  localparam int SW = $clog2(ROWS_PER_TILE + 1);
  localparam logic [SW-1:0] ROWS_S     = SW'(ROWS_PER_TILE);
  localparam logic [CW:0]   CREDIT_MAX = {1'b0, {CW{1'b1}}};

  feed_state_t r_state;
  feed_state_t w_next_state;

  logic                 r_req_d;
  logic [CW-1:0]        r_credit;
  logic [CW-1:0]        r_discard;
  logic [SW-1:0]        r_sent;
  logic [ROW_WIDTH-1:0] r_vec;
  logic                 r_valid;
  logic                 r_tile_done;
  logic                 r_err_abort;

  logic [ROW_WIDTH-1:0] w_fifo_data;
  logic                 w_full;
  logic                 w_empty;
  logic [LW-1:0]        w_level;
  logic [LW-1:0]        w_pop_n;

  logic                 w_req_rise;
  logic                 w_tready;
  logic                 w_beat;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_abort;
  logic                 w_tile_done_set;
  logic                 w_absorb;
  logic [CW-1:0]        w_owed;
  logic [CW-1:0]        w_level_cw;
  logic [CW-1:0]        w_flush;
  logic [CW-1:0]        w_rem;
  logic [CW:0]          w_credit_add;
  logic [CW-1:0]        w_credit_next;
  logic [CW-1:0]        w_discard_next;

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_WIDTH)
  ) u_row_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_axis_tdata),
    .i_pop_n (w_pop_n),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // ---------------- egress FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FEED_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FEED_IDLE:  if (i_load_en) w_next_state = FEED_SERVE;
      FEED_SERVE: begin
        if (r_sent == ROWS_S)  w_next_state = FEED_DONE;
        else if (!i_load_en)   w_next_state = FEED_IDLE;
      end
      FEED_DONE:  if (!i_load_en) w_next_state = FEED_IDLE;
      default:    w_next_state = FEED_IDLE;
    endcase
  end

  // The last row is popped while sent is still ROWS-1; sent==ROWS marks the cycle that row is shown.
  always_comb begin
    w_pop           = 1'b0;
    w_abort         = 1'b0;
    w_tile_done_set = 1'b0;
    if (r_state == FEED_SERVE) begin
      if (r_sent == ROWS_S) begin
        w_tile_done_set = 1'b1;
      end else if (!i_load_en) begin
        w_abort = 1'b1;
      end else if (!w_empty) begin
        w_pop = 1'b1;
      end
    end
  end

  // ---------------- abort bookkeeping ----------------
  // Rows owed to the aborted tile are flushed from the FIFO; whatever has not arrived yet
  // (including a beat landing in the abort cycle) is skipped on ingress via the discard count.
  assign w_owed     = CW'(ROWS_PER_TILE) - CW'(r_sent);
  assign w_level_cw = CW'(w_level);
  assign w_flush    = (w_owed < w_level_cw) ? w_owed : w_level_cw;
  assign w_rem      = w_owed - w_flush;
  assign w_absorb   = w_abort & w_beat & (r_discard == '0) & (w_rem != '0);

  always_comb begin
    w_pop_n = '0;
    if (w_abort) begin
      w_pop_n = LW'(w_flush);
    end else if (w_pop) begin
      w_pop_n = LW'(1);
    end
  end

  always_comb begin
    w_discard_next = r_discard;
    if (w_beat && (r_discard != '0)) begin
      w_discard_next = w_discard_next - CW'(1);
    end
    if (w_abort) begin
      w_discard_next = w_discard_next + w_rem - CW'(w_absorb);
    end
  end

  // ---------------- credit and ingress ----------------
  assign w_req_rise    = i_dma_req & ~r_req_d;
  assign w_tready      = (r_credit != '0) & ~w_full;
  assign w_beat        = s_axis_tvalid & w_tready;
  assign w_push        = w_beat & (r_discard == '0) & ~w_absorb;
  assign s_axis_tready = w_tready;

  always_comb begin
    w_credit_add = {1'b0, r_credit};
    if (w_req_rise) begin
      w_credit_add = w_credit_add + (CW+1)'(ROWS_PER_TILE);
    end
    if (w_credit_add > CREDIT_MAX) begin
      w_credit_add = CREDIT_MAX;
    end
    w_credit_next = w_credit_add[CW-1:0] - CW'(w_beat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d     <= 1'b0;
      r_credit    <= '0;
      r_discard   <= '0;
      r_sent      <= '0;
      r_vec       <= '0;
      r_valid     <= 1'b0;
      r_tile_done <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_req_d     <= i_dma_req;
      r_credit    <= w_credit_next;
      r_discard   <= w_discard_next;
      r_valid     <= w_pop;
      r_tile_done <= w_tile_done_set;
      if (w_pop) begin
        r_vec <= w_fifo_data;
      end
      if (r_state == FEED_IDLE) begin
        r_sent <= '0;
      end else if (w_pop) begin
        r_sent <= r_sent + SW'(1);
      end
      if (w_abort) begin
        r_err_abort <= 1'b1;
      end
    end
  end

  assign o_weight_vec   = r_vec;
  assign o_weight_valid = r_valid;
  assign o_tile_done    = r_tile_done;
  assign o_err_abort    = r_err_abort;
  assign o_fifo_level   = w_level;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_weight_row_feeder.sv
`timescale 1ns/1ps
// Scenario bench for weight_row_feeder: DMA driver tasks, an output scoreboard fed from an
// expected-row queue, and per-scenario checks of level, ready, abort and tile-done behaviour.
module tb_weight_row_feeder;
  import weight_row_feeder_pkg::*;

  localparam int ROWS  = ARRAY_ROW;
  localparam int RW    = ARRAY_COL * DATA_WIDTH;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          i_dma_req;
  logic          i_load_en;
  logic [RW-1:0] o_weight_vec;
  logic          o_weight_valid;
  logic          o_tile_done;
  logic          o_err_abort;
  logic [LW-1:0] o_fifo_level;
  logic [1:0]    o_dbg_state;

  weight_row_feeder #(
    .ROWS_PER_TILE (ROWS),
    .ROW_WIDTH     (RW),
    .FIFO_DEPTH    (DEPTH),
    .CREDIT_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .i_dma_req      (i_dma_req),
    .i_load_en      (i_load_en),
    .o_weight_vec   (o_weight_vec),
    .o_weight_valid (o_weight_valid),
    .o_tile_done    (o_tile_done),
    .o_err_abort    (o_err_abort),
    .o_fifo_level   (o_fifo_level),
    .o_dbg_state    (o_dbg_state)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  int  cyc = 0;
  int  last_valid_cyc = -10;
  int  phase_cnt = 0;
  int  done_cnt = 0;
  bit  prev_valid = 0;
  bit  b2b_seen = 0;
  int  k;
  int  overlap_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (o_weight_valid) begin
      phase_cnt = phase_cnt + 1;
      if (prev_valid) b2b_seen = 1;
      last_valid_cyc = cyc;
      compared = compared + 1;
      if (exp_q.size() == 0) begin
        mismatched = mismatched + 1;
        $display("FAIL row_unexpected: got %0h, no row expected", o_weight_vec);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_weight_vec !== mon_exp) begin
          mismatched = mismatched + 1;
          $display("FAIL row_data: got %0h expected %0h", o_weight_vec, mon_exp);
        end
      end
      compared = compared + 1;
      if (o_dbg_state !== FEED_SERVE) begin
        mismatched = mismatched + 1;
        $display("FAIL valid_outside_serve: state %0d expected %0d", o_dbg_state, FEED_SERVE);
      end
    end
    if (o_tile_done) begin
      done_cnt = done_cnt + 1;
      compared = compared + 1;
      if (cyc !== last_valid_cyc + 1) begin
        mismatched = mismatched + 1;
        $display("FAIL tile_done_timing: at cycle %0d expected %0d", cyc, last_valid_cyc + 1);
      end
    end
    prev_valid = o_weight_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    i_dma_req = 1'b0;
    i_load_en = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    phase_cnt = 0;
    tick();
  endtask

  task automatic pulse_req();
    i_dma_req = 1'b1;
    tick();
    i_dma_req = 1'b0;
    tick();
  endtask

  task automatic dma_beat(input logic [RW-1:0] d);
    int t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && t < 300) begin
      tick();
      t++;
    end
    compared++;
    if (!s_axis_tready) begin
      mismatched++;
      $display("FAIL dma_beat_timeout: tready %0b expected 1 for row %0h", s_axis_tready, d);
    end
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic run_load(input int n);
    int d0;
    int t;
    d0 = done_cnt;
    phase_cnt = 0;
    i_load_en = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      tick();
      t++;
    end
    compared++;
    if (done_cnt !== d0 + 1) begin
      mismatched++;
      $display("FAIL tile_done_count: got %0d expected %0d", done_cnt - d0, 1);
    end
    compared++;
    if (phase_cnt !== n) begin
      mismatched++;
      $display("FAIL rows_per_phase: got %0d expected %0d", phase_cnt, n);
    end
    i_load_en = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b1;
    i_dma_req = 1'b0;
    i_load_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    compared++; if (o_weight_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b expected 0", o_weight_valid); end
    compared++; if (o_tile_done !== 1'b0) begin mismatched++; $display("FAIL reset_tile_done: got %0b expected 0", o_tile_done); end
    compared++; if (o_err_abort !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %0b expected 0", o_err_abort); end
    compared++; if (o_fifo_level !== '0) begin mismatched++; $display("FAIL reset_level: got %0d expected 0", o_fifo_level); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL reset_tready: got %0b expected 0", s_axis_tready); end
    compared++; if (o_weight_vec !== '0) begin mismatched++; $display("FAIL reset_vec: got %0h expected 0", o_weight_vec); end
    compared++; if (o_dbg_state !== FEED_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, FEED_IDLE); end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_one_tile();
    pulse_req();
    for (int i = 0; i < ROWS; i++) begin
      exp_q.push_back(RW'(i));
      dma_beat(RW'(i));
    end
    compared++; if (o_fifo_level !== LW'(ROWS)) begin mismatched++; $display("FAIL one_tile_level: got %0d expected %0d", o_fifo_level, ROWS); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL one_tile_credit_spent: tready %0b expected 0", s_axis_tready); end
    run_load(ROWS);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL one_tile_drained: %0d rows left expected 0", exp_q.size()); end
  endtask

  task automatic test_bubbles();
    b2b_seen = 0;
    pulse_req();
    fork
      run_load(ROWS);
      begin
        tick();
        for (int i = 0; i < ROWS; i++) begin
          exp_q.push_back(RW'(32'h300 + i));
          dma_beat(RW'(32'h300 + i));
          tick();
        end
      end
    join
    compared++; if (b2b_seen !== 1'b0) begin mismatched++; $display("FAIL bubble_gaps: back-to-back %0b expected 0", b2b_seen); end
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL bubble_drained: %0d rows left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pulse_req();
    pulse_req();
    pulse_req();
    k = 0;
    fork
      begin
        int t;
        t = 0;
        while (k < 3 * ROWS && t < 600) begin
          s_axis_tdata  = RW'(32'h400 + k);
          s_axis_tvalid = 1'b1;
          if (s_axis_tready) begin
            exp_q.push_back(RW'(32'h400 + k));
            k++;
          end
          tick();
          t++;
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        repeat (40) tick();
        @(negedge clk);
        compared++; if (k !== DEPTH) begin mismatched++; $display("FAIL bp_accepted: got %0d expected %0d", k, DEPTH); end
        compared++; if (o_fifo_level !== LW'(DEPTH)) begin mismatched++; $display("FAIL bp_level: got %0d expected %0d", o_fifo_level, DEPTH); end
        compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL bp_tready_full: got %0b expected 0", s_axis_tready); end
        tick();
        run_load(ROWS);
        run_load(ROWS);
        run_load(ROWS);
      end
    join
    compared++; if (k !== 3 * ROWS) begin mismatched++; $display("FAIL bp_total: got %0d expected %0d", k, 3 * ROWS); end
    compared++; if (o_fifo_level !== '0) begin mismatched++; $display("FAIL bp_final_level: got %0d expected 0", o_fifo_level); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL bp_final_tready: got %0b expected 0", s_axis_tready); end
  endtask

  task automatic test_abort();
    pulse_req();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) exp_q.push_back(RW'(32'h500 + i));
      dma_beat(RW'(32'h500 + i));
    end
    phase_cnt = 0;
    i_load_en = 1'b1;
    repeat (7) tick();
    i_load_en = 1'b0;
    tick();
    compared++; if (o_err_abort !== 1'b1) begin mismatched++; $display("FAIL abort_flag: got %0b expected 1", o_err_abort); end
    compared++; if (o_fifo_level !== '0) begin mismatched++; $display("FAIL abort_flush_level: got %0d expected 0", o_fifo_level); end
    compared++; if (phase_cnt !== 6) begin mismatched++; $display("FAIL abort_rows_out: got %0d expected 6", phase_cnt); end
    compared++; if (o_dbg_state !== FEED_IDLE) begin mismatched++; $display("FAIL abort_state: got %0d expected %0d", o_dbg_state, FEED_IDLE); end
    for (int i = 8; i < ROWS; i++) dma_beat(RW'(32'h500 + i));
    compared++; if (o_fifo_level !== '0) begin mismatched++; $display("FAIL abort_discard_level: got %0d expected 0", o_fifo_level); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL abort_credit_spent: tready %0b expected 0", s_axis_tready); end
    pulse_req();
    for (int i = 0; i < ROWS; i++) begin
      exp_q.push_back(RW'(100 + i));
      dma_beat(RW'(100 + i));
    end
    run_load(ROWS);
    compared++; if (o_err_abort !== 1'b1) begin mismatched++; $display("FAIL abort_sticky: got %0b expected 1", o_err_abort); end
  endtask

  task automatic test_reset_mid_serve();
    apply_reset();
    pulse_req();
    for (int i = 0; i < ROWS; i++) begin
      if (i < 4) exp_q.push_back(RW'(32'h700 + i));
      dma_beat(RW'(32'h700 + i));
    end
    phase_cnt = 0;
    i_load_en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_load_en = 1'b0;
    compared++; if (o_weight_valid !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %0b expected 0", o_weight_valid); end
    compared++; if (o_weight_vec !== '0) begin mismatched++; $display("FAIL rst_mid_vec: got %0h expected 0", o_weight_vec); end
    compared++; if (o_fifo_level !== '0) begin mismatched++; $display("FAIL rst_mid_level: got %0d expected 0", o_fifo_level); end
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL rst_mid_tready: got %0b expected 0", s_axis_tready); end
    compared++; if (o_dbg_state !== FEED_IDLE) begin mismatched++; $display("FAIL rst_mid_state: got %0d expected %0d", o_dbg_state, FEED_IDLE); end
    compared++; if (phase_cnt !== 4) begin mismatched++; $display("FAIL rst_mid_rows_out: got %0d expected 4", phase_cnt); end
    repeat (3) tick();
    compared++; if (s_axis_tready !== 1'b0) begin mismatched++; $display("FAIL rst_mid_tready_hold: got %0b expected 0", s_axis_tready); end
    pulse_req();
    compared++; if (s_axis_tready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_new_req: tready %0b expected 1", s_axis_tready); end
  endtask

  task automatic test_prefetch();
    apply_reset();
    pulse_req();
    for (int i = 0; i < ROWS; i++) begin
      exp_q.push_back(RW'(32'h800 + i));
      dma_beat(RW'(32'h800 + i));
    end
    overlap_cnt = 0;
    fork
      run_load(ROWS);
      begin
        tick();
        pulse_req();
        for (int i = 0; i < ROWS; i++) begin
          exp_q.push_back(RW'(32'h900 + i));
          if (o_dbg_state == FEED_SERVE) overlap_cnt++;
          dma_beat(RW'(32'h900 + i));
        end
      end
    join
    compared++; if (overlap_cnt == 0) begin mismatched++; $display("FAIL prefetch_overlap: got %0d beats during serve expected >0", overlap_cnt); end
    compared++; if (o_fifo_level !== LW'(ROWS)) begin mismatched++; $display("FAIL prefetch_level: got %0d expected %0d", o_fifo_level, ROWS); end
    i_load_en = 1'b1;
    tick();
    compared++; if (o_weight_valid !== 1'b0) begin mismatched++; $display("FAIL prefetch_latency_early: got %0b expected 0", o_weight_valid); end
    tick();
    compared++; if (o_weight_valid !== 1'b1) begin mismatched++; $display("FAIL prefetch_latency: got %0b expected 1", o_weight_valid); end
    run_load(ROWS);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL prefetch_drained: %0d rows left expected 0", exp_q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    i_dma_req = 1'b0;
    i_load_en = 1'b0;
    test_reset();
    test_one_tile();
    test_bubbles();
    test_back_to_back();
    test_abort();
    test_reset_mid_serve();
    test_prefetch();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
